// File: rtl/tapped_delay_line_pkg.sv
// Shared definitions for the tapped delay line: default geometry and width helpers.
// Also holds the tap clamp so the data path and the fill tracker agree on it.
package tapped_delay_line_pkg;

    localparam int unsigned DefaultSize  = 10;
    localparam int unsigned DefaultWidth = 8;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < n; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Out-of-range taps select the last stage.
    function automatic int unsigned clamp_tap(input int unsigned tap, input int unsigned size);
        return (tap >= size) ? (size - 1) : tap;
    endfunction

endpackage

// File: rtl/fill_tracker.sv
// Saturating count of words written since reset, with the derived valid/full flags.
// The count lets valid reflect whether the selected stage has been reached yet.
module fill_tracker
    import tapped_delay_line_pkg::*;
#(
    parameter int unsigned size = DefaultSize
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [clog2(size)-1:0]   tap,
    output logic                     valid,
    output logic                     full
);

    localparam int unsigned FillW = clog2(size + 1);
    localparam logic [FillW-1:0] FillMax = FillW'(size);

    logic [FillW-1:0] fill_q;
    logic [FillW-1:0] fill_d;
    logic             at_max;
    int unsigned      tap_eff;

    assign at_max = (fill_q == FillMax);

    always_comb begin
        fill_d = fill_q;
        if (reset) begin
            fill_d = '0;
        end else if (enable && !at_max) begin
            fill_d = fill_q + FillW'(1);
        end
    end

    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    always_comb begin
        tap_eff = clamp_tap(32'(tap), size);
        valid   = 32'(fill_q) > tap_eff;
        full    = at_max;
    end

endmodule

// File: rtl/tapped_delay_line.sv
// Shift register of `size` stages with a combinationally selected output tap.
// Shifts only on enabled edges; a synchronous reset clears data and fill state.
module tapped_delay_line
    import tapped_delay_line_pkg::*;
#(
    parameter int unsigned size  = DefaultSize,
    parameter int unsigned width = DefaultWidth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [width-1:0]         in,
    input  logic                     enable,
    input  logic [clog2(size)-1:0]   tap,
    output logic [width-1:0]         out,
    output logic                     valid,
    output logic                     full
);

    localparam int unsigned TapW = clog2(size);

    logic [size-1:0][width-1:0] stages;
    logic [TapW-1:0]            tap_eff;

    for (genvar i = 0; i < size; i++) begin : g_stage
        logic [width-1:0] stage_q;
        logic [width-1:0] stage_d;
        logic [width-1:0] stage_src;

        if (i == 0) begin : g_head
            assign stage_src = in;
        end else begin : g_body
            assign stage_src = stages[i-1];
        end

        always_comb begin
            stage_d = stage_q;
            if (reset) begin
                stage_d = '0;
            end else if (enable) begin
                stage_d = stage_src;
            end
        end

        always_ff @(posedge clk) begin
            stage_q <= stage_d;
        end

        assign stages[i] = stage_q;
    end

    always_comb begin
        tap_eff = TapW'(clamp_tap(32'(tap), size));
        out     = stages[tap_eff];
    end

    fill_tracker #(
        .size (size)
    ) u_fill_tracker (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tap    (tap),
        .valid  (valid),
        .full   (full)
    );

endmodule
